// File: rtl/spi_master_32bit.sv
// spi_master_32bit: 32-bit SPI mode-0 master with an active-low chip select.
// A frame is LEAD, then 32 HIGH/LOW pairs, then LAG, with CS low throughout.
// A GAP phase follows with CS high before the master returns to IDLE.
// Every phase lasts HALF_PERIOD clk cycles.
// Optional feature macro: SPI_MASTER_FRAME_CNT_EN adds a 16-bit frame_cnt
// output that counts completed frames and wraps.
module spi_master_32bit #(
   parameter int unsigned HALF_PERIOD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] tx_data,
   output logic [31:0] rx_data,
   output logic        busy,
   output logic        done,
`ifdef SPI_MASTER_FRAME_CNT_EN
   output logic [15:0] frame_cnt,
`endif
   output logic        SPI_CLK,
   output logic        SPI_PICO,
   output logic        SPI_CS,
   input  logic        SPI_POCI
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned BIT_W  = 6;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_PERIOD - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] NUM_BITS = BIT_W'(DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      LAG,
      GAP
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt, div_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_nxt;
   // bit 31 of the frame goes straight to SPI_PICO, so only 31 bits are held
   logic [DATA_W-2:0]   tx_sr, tx_sr_nxt;
   logic [DATA_W-1:0]   rx_sr, rx_sr_nxt;
   logic [DATA_W-1:0]   rx_data_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                sclk_nxt;
   logic                pico_nxt;
   logic                cs_nxt;
   logic                phase_end;
`ifdef SPI_MASTER_FRAME_CNT_EN
   logic [15:0]         frame_cnt_nxt;
`endif

   assign phase_end = (div_cnt == '0);

   // State, counters, shift registers and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         SPI_CLK  <= 1'b0;
         SPI_PICO <= 1'b0;
         SPI_CS   <= 1'b1;
`ifdef SPI_MASTER_FRAME_CNT_EN
         frame_cnt <= '0;
`endif
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_nxt;
         bit_cnt  <= bit_nxt;
         tx_sr    <= tx_sr_nxt;
         rx_sr    <= rx_sr_nxt;
         rx_data  <= rx_data_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         SPI_CLK  <= sclk_nxt;
         SPI_PICO <= pico_nxt;
         SPI_CS   <= cs_nxt;
`ifdef SPI_MASTER_FRAME_CNT_EN
         frame_cnt <= frame_cnt_nxt;
`endif
      end
   end

   // Next-state and next-output logic; every phase change reloads the divider
   always_comb begin
      state_nxt   = state;
      div_nxt     = phase_end ? DIV_LOAD : div_cnt - DIV_W'(1);
      bit_nxt     = bit_cnt;
      tx_sr_nxt   = tx_sr;
      rx_sr_nxt   = rx_sr;
      rx_data_nxt = rx_data;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      sclk_nxt    = SPI_CLK;
      pico_nxt    = SPI_PICO;
      cs_nxt      = SPI_CS;
`ifdef SPI_MASTER_FRAME_CNT_EN
      frame_cnt_nxt = frame_cnt;
`endif

      case (state)
         IDLE: begin
            div_nxt  = DIV_LOAD;
            bit_nxt  = '0;
            cs_nxt   = 1'b1;
            sclk_nxt = 1'b0;
            pico_nxt = 1'b0;
            busy_nxt = 1'b0;
            if (start) begin
               state_nxt = LEAD;
               tx_sr_nxt = tx_data[DATA_W-2:0];
               rx_sr_nxt = '0;
               cs_nxt    = 1'b0;
               pico_nxt  = tx_data[DATA_W-1];
               busy_nxt  = 1'b1;
            end
         end

         LEAD: begin
            if (phase_end) begin
               state_nxt = HIGH;
               sclk_nxt  = 1'b1;
            end
         end

         // POCI is captured on the last cycle of the high phase
         HIGH: begin
            if (phase_end) begin
               state_nxt = LOW;
               sclk_nxt  = 1'b0;
               rx_sr_nxt = {rx_sr[DATA_W-2:0], SPI_POCI};
               bit_nxt   = bit_cnt + BIT_W'(1);
               // after the final bit PICO keeps its value through LAG
               if (bit_cnt != LAST_BIT) begin
                  pico_nxt  = tx_sr[DATA_W-2];
                  tx_sr_nxt = {tx_sr[DATA_W-3:0], 1'b0};
               end
            end
         end

         LOW: begin
            if (phase_end) begin
               if (bit_cnt == NUM_BITS) begin
                  state_nxt = LAG;
               end else begin
                  state_nxt = HIGH;
                  sclk_nxt  = 1'b1;
               end
            end
         end

         LAG: begin
            if (phase_end) begin
               state_nxt   = GAP;
               cs_nxt      = 1'b1;
               pico_nxt    = 1'b0;
               rx_data_nxt = rx_sr;
               done_nxt    = 1'b1;
`ifdef SPI_MASTER_FRAME_CNT_EN
               frame_cnt_nxt = frame_cnt + 16'd1;
`endif
            end
         end

         // busy drops right after the done cycle; start stays ignored here
         GAP: begin
            if (done) begin
               busy_nxt = 1'b0;
            end
            if (phase_end) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
